dice_judge: RTL and testbench



---
 rtl/dice_pkg.sv | 23 ++
 rtl/dice_judge_if.sv | 12 +
 rtl/key_pulse.sv | 29 ++
 rtl/dice_judge.sv | 82 ++++++++
 tb/tb_dice_judge.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/dice_pkg.sv
// Shared types and codes for the dice game control stage and the LED stage.
package dice_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    JUDGE  = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [2:0] WIN_NONE = 3'd0;
  localparam logic [2:0] WIN_A    = 3'd1;
  localparam logic [2:0] WIN_B    = 3'd2;
  localparam logic [2:0] WIN_TIE  = 3'd3;

  localparam logic [2:0] DIE_MIN = 3'd1;
  localparam logic [2:0] DIE_MAX = 3'd6;

  function automatic logic [2:0] judge(input logic [2:0] a, input logic [2:0] b);
    if (a > b)      return WIN_A;
    else if (b > a) return WIN_B;
    else            return WIN_TIE;
  endfunction
endpackage

// File: rtl/dice_judge_if.sv
// Player keys in, latched dice / result code / busy out.
interface dice_judge_if;
  logic       key_a;
  logic       key_b;
  logic [2:0] dice_a;
  logic [2:0] dice_b;
  logic [2:0] win;
  logic       busy;

  modport slave  (input key_a, key_b, output dice_a, dice_b, win, busy);
  modport master (output key_a, key_b, input dice_a, dice_b, win, busy);
endinterface

// File: rtl/key_pulse.sv
// Raw key -> 2-flop sync -> debounce -> single-cycle press pulse per press.
module key_pulse #(
  parameter int DEB_CYCLES = 4,
  parameter int CW         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic press
);
  localparam logic [CW-1:0] DEB = CW'(DEB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Counter parks at DEB+1 so a held key fires once until it is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_in};
      press <= sync[1] && (cnt == DEB);
      if (!sync[1])       cnt <= '0;
      else if (cnt <= DEB) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dice_judge.sv
// Two-player dice game control: A rolls, B rolls, judge, hold result on win.
module dice_judge
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int SHOW_CYCLES = 16,
  parameter int CW          = 26
) (
  input logic         clk,
  input logic         rst_n,
  dice_judge_if.slave bus
);
  state_t        state, state_n;
  logic [2:0]    dice_a, dice_a_n, dice_b, dice_b_n, win, win_n;
  logic [2:0]    cnt_a, cnt_b;
  logic [CW-1:0] timer, timer_n;
  logic          press_a, press_b;

  key_pulse #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_key_a (
    .clk(clk), .rst_n(rst_n), .key_in(bus.key_a), .press(press_a));
  key_pulse #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_key_b (
    .clk(clk), .rst_n(rst_n), .key_in(bus.key_b), .press(press_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dice_a <= '0;
      dice_b <= '0;
      win    <= WIN_NONE;
      timer  <= '0;
      cnt_a  <= DIE_MIN;
      cnt_b  <= DIE_MAX;
    end else begin
      state  <= state_n;
      dice_a <= dice_a_n;
      dice_b <= dice_b_n;
      win    <= win_n;
      timer  <= timer_n;
      cnt_a  <= (cnt_a == DIE_MAX) ? DIE_MIN : cnt_a + 3'd1;
      cnt_b  <= (cnt_b == DIE_MIN) ? DIE_MAX : cnt_b - 3'd1;
    end
  end

  always_comb begin
    state_n  = state;
    dice_a_n = dice_a;
    dice_b_n = dice_b;
    win_n    = win;
    timer_n  = timer;
    case (state)
      IDLE: if (press_a) begin
        dice_a_n = cnt_a;
        dice_b_n = '0;
        state_n  = WAIT_B;
      end
      WAIT_B: if (press_b) begin
        dice_b_n = cnt_b;
        state_n  = JUDGE;
      end
      JUDGE: begin
        win_n   = judge(dice_a, dice_b);
        timer_n = CW'(SHOW_CYCLES - 1);
        state_n = SHOW;
      end
      SHOW: begin
        // Timer runs SHOW_CYCLES-1..0, so win stays up for SHOW_CYCLES cycles.
        if (timer == '0) begin
          win_n   = WIN_NONE;
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dice_a = dice_a;
  assign bus.dice_b = dice_b;
  assign bus.win    = win;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_dice_judge.sv
// Directed bench for dice_judge; game results go through a scoreboard queue.
module tb_dice_judge;
  localparam int SHOW = 16;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] w;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n = 0;
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  logic [2:0] cur_win = '0;
  res_t sb[$];

  dice_judge_if bus ();

  dice_judge #(.DEB_CYCLES(4), .SHOW_CYCLES(SHOW), .CW(26)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Edges since reset release; die values follow from this alone.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) n <= 0;
    else        n <= n + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Stall until the next edge's count n+1 satisfies (n+1)%6 == km.
  task automatic align(input int km);
    while (((n + 1) % 6) != km) tick();
  endtask

  function automatic int km_for(input bit is_b, input int val);
    return is_b ? ((6 - val) % 6) : (val - 1);
  endfunction

  function automatic logic [2:0] exp_win(input int a, input int b);
    if (a > b) return 3'd1;
    if (b > a) return 3'd2;
    return 3'd3;
  endfunction

  // Key raised before edge k; press pulse is visible at tick 7, latch at tick 8.
  task automatic press(input logic [1:0] mask, input int val, input int hold, output logic pre_busy);
    align(km_for(!mask[0], val));
    if (mask[0]) bus.key_a = 1'b1;
    if (mask[1]) bus.key_b = 1'b1;
    repeat (7) tick();
    pre_busy = bus.busy;
    repeat (hold - 7) tick();
    if (mask[0]) bus.key_a = 1'b0;
    if (mask[1]) bus.key_b = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (bus.busy && i < 60) begin
      tick();
      i++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic finish_b(input int va, input int vb);
    logic pb;
    sb.push_back('{a: 3'(va), b: 3'(vb), w: exp_win(va, vb)});
    press(2'b10, vb, 8, pb);
    chk("b_latch", bus.dice_b, 8'(vb));
    chk("win_before_judge", bus.win, 0);
    wait_idle();
    chk("hold_a", bus.dice_a, 8'(va));
    chk("hold_b", bus.dice_b, 8'(vb));
  endtask

  task automatic game(input int va, input int vb);
    logic pb;
    press(2'b01, va, 8, pb);
    chk("a_pre_busy", pb, 0);
    chk("a_busy", bus.busy, 1);
    chk("a_latch", bus.dice_a, 8'(va));
    chk("a_clears_b", bus.dice_b, 0);
    finish_b(va, vb);
  endtask

  // Result monitor: pop on win rising, then check stability and exact duration.
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      cur_win = '0;
    end else if (bus.win !== 3'd0) begin
      if (run == 0) begin
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          res_t e;
          e = sb.pop_front();
          chk("res_dice_a", bus.dice_a, e.a);
          chk("res_dice_b", bus.dice_b, e.b);
          chk("res_win", bus.win, e.w);
          cur_win = e.w;
        end
      end else begin
        chk("win_stable", bus.win, cur_win);
      end
      run++;
    end else if (run != 0) begin
      chk("win_cycles", 8'(run), 8'(SHOW));
      chk("busy_after_show", bus.busy, 0);
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pb;
    bus.key_a = 1'b0;
    bus.key_b = 1'b0;
    repeat (3) tick();
    chk("rst_dice_a", bus.dice_a, 0);
    chk("rst_dice_b", bus.dice_b, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    game(5, 2);
    game(2, 6);
    game(3, 3);

    // Glitchy key never reaches the debounce threshold.
    bus.key_a = 1'b1; repeat (3) tick();
    bus.key_a = 1'b0; tick();
    bus.key_a = 1'b1; repeat (3) tick();
    bus.key_a = 1'b0; repeat (8) tick();
    chk("glitch_busy", bus.busy, 0);
    chk("glitch_dice_a", bus.dice_a, 3);

    press(2'b01, 4, 10, pb);
    chk("deb_pre_busy", pb, 0);
    chk("deb_busy", bus.busy, 1);
    chk("deb_dice_a", bus.dice_a, 4);

    press(2'b01, 1, 8, pb);
    chk("reroll_dice_a", bus.dice_a, 4);
    chk("reroll_dice_b", bus.dice_b, 0);
    chk("reroll_busy", bus.busy, 1);
    finish_b(4, 5);

    press(2'b10, 6, 8, pb);
    chk("b_idle_busy", bus.busy, 0);
    chk("b_idle_dice_a", bus.dice_a, 4);
    chk("b_idle_dice_b", bus.dice_b, 5);

    press(2'b11, 6, 8, pb);
    repeat (4) tick();
    chk("both_busy", bus.busy, 1);
    chk("both_dice_a", bus.dice_a, 6);
    chk("both_dice_b", bus.dice_b, 0);
    chk("both_win", bus.win, 0);
    finish_b(6, 1);

    // key_a held across a whole game must not start another.
    align(km_for(1'b0, 2));
    bus.key_a = 1'b1;
    repeat (8) tick();
    chk("held_busy", bus.busy, 1);
    chk("held_dice_a", bus.dice_a, 2);
    finish_b(2, 2);
    repeat (10) tick();
    chk("held_no_retrigger", bus.busy, 0);
    bus.key_a = 1'b0;
    repeat (3) tick();
    game(1, 4);

    // Reset in the middle of SHOW.
    press(2'b01, 5, 8, pb);
    sb.push_back('{a: 3'd5, b: 3'd2, w: 3'd1});
    press(2'b10, 2, 8, pb);
    repeat (5) tick();
    chk("mid_show_win", bus.win, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_win", bus.win, 0);
    chk("async_rst_dice_a", bus.dice_a, 0);
    chk("async_rst_dice_b", bus.dice_b, 0);
    chk("async_rst_busy", bus.busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    game(6, 1);

    chk("sb_drained", 8'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
